npn_tt_sequencer: RTL
=====================

// Module: npn_tt_sequencer
// PURPOSE
//  Sequencer/configurator for one external 4-input/1-output combinational function (fn_x[3:0] -> fn_y).
//  Applies an NPN transform: input permutation, input negation, output negation.
//  Sweeps all 16 minterms, captures the transformed 16-bit truth table, compares it to an expected table.
//  Sits between a test/config host (start/done handshake) and the function instance it drives.
// PARAMETERS
//  SETTLE  1  cycles each minterm is held on fn_x before fn_y is sampled (legal: >=1)
// PORTS
//  clk      in   1   single clock, rising edge
//  rst      in   1   synchronous reset, active-high
//  start    in   1   run request; accepted only in IDLE
//  perm     in   8   perm[2i+1:2i] = minterm bit routed to fn_x[i]; must be a bijection
//  neg_in   in   4   neg_in[i]=1 inverts fn_x[i]
//  neg_out  in   1   1 inverts sampled fn_y
//  exp_tt   in   16  expected truth table, bit m = value for minterm m
//  fn_x     out  4   drive to function inputs
//  fn_y     in   1   function output
//  busy     out  1   high in RUN
//  done     out  1   one-cycle pulse at end of run or on rejected start
//  err      out  1   valid with done: 1 = perm not a bijection, run skipped
//  tt       out  16  captured (transformed) truth table
//  match    out  1   valid with done: tt == captured exp_tt
// BEHAVIOUR
//  Reset: state IDLE; fn_x=0, busy=0, done=0, err=0, tt=0, match=0; all config regs 0.
//   Reset mid-run aborts immediately; no done pulse.
//  States: IDLE -> (start, perm valid) RUN; IDLE -> (start, perm invalid) DONE with err=1; RUN -> DONE; DONE -> IDLE.
//  Accept (IDLE & start, edge E0): capture perm, neg_in, neg_out, exp_tt; clear tt; m=0, cnt=0.
//   start in RUN or DONE is ignored; inputs changing during RUN have no effect.
//  RUN:
//   - fn_x[i] = m[perm_r[2i+1:2i]] ^ neg_in_r[i], decoded from registered m and config; fn_x=0 outside RUN.
//   - Each edge: if cnt==SETTLE-1 then tt[m] <= fn_y ^ neg_out_r and cnt<=0.
//     m==15: go to DONE. Otherwise m<=m+1.
//   - Else cnt<=cnt+1.
//   - Samples occur at edges E0+SETTLE*(m+1); last sample at E0+16*SETTLE.
//  DONE (exactly one cycle, the cycle after the last sample edge):
//   - done=1, busy=0; match=(tt==exp_r), held until next accept; err as above.
//   - Rejected start: done/err high in the cycle after E0; tt untouched; match=0; fn_x stays 0.
//  tt holds its value in IDLE until the next accepted start.
//  Widths: m 4-bit, no wrap past 15; cnt sized clog2(SETTLE)+1.
// TESTING  (bench model fn_y = fn_x[0] & fn_x[1], SETTLE=1 unless noted)
//  1. perm=8'hE4, neg_in=0, neg_out=0, exp_tt=16'h8888 -> tt=16'h8888, match=1, err=0; done in the cycle after E16.
//  2. neg_in=4'b0001 -> tt=16'h4444. neg_out=1 with neg_in=0 -> tt=16'h7777; exp_tt=16'h8888 gives match=0.
//  3. perm=8'hC6 (fn_x0<-m2, fn_x2<-m0) -> tt=16'hC0C0.
//  4. perm=8'h00 -> done=1, err=1 in the next cycle; fn_x stays 0; busy never rises; tt keeps its prior value.
//  5. start re-pulsed at m=5 -> ignored, result as test 1. rst at m=7 -> next cycle fn_x=0, busy=0, tt=0; no done.
//  6. SETTLE=3 -> each fn_x value held 3 cycles; done in the cycle after E48; same tt as test 1.

Source files
------------

// File: rtl/npn_tt_sequencer.sv
// NPN-transform truth-table sequencer: drives a 4-in/1-out function through all
// 16 minterms under a configured input permutation/negation and output negation.
module npn_tt_sequencer #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  perm,
    input  logic [3:0]  neg_in,
    input  logic        neg_out,
    input  logic [15:0] exp_tt,
    output logic [3:0]  fn_x,
    input  logic        fn_y,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] tt,
    output logic        match
);

    localparam int CNT_W = $clog2(SETTLE) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [7:0]       perm_r;
    logic [3:0]       neg_in_r;
    logic             neg_out_r;
    logic [15:0]      exp_r;
    logic [3:0]       m;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      tt_r;
    logic [15:0]      tt_next;
    logic             err_r;
    logic             match_r;
    logic [3:0]       seen;
    logic             perm_ok;
    logic             accept;
    logic             sample;

    // A permutation is a bijection exactly when its four selectors cover all four minterm bits.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        seen = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            seen[perm[2*i +: 2]] = 1'b1;
        end
        perm_ok = &seen;
    end

    assign accept = (state == S_IDLE) && start;
    assign sample = (state == S_RUN) && (cnt == CNT_LAST);

    always_comb begin
        tt_next    = tt_r;
        tt_next[m] = fn_y ^ neg_out_r;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = perm_ok ? S_RUN : S_DONE;
            S_RUN:  if (sample && (m == 4'd15)) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perm_r    <= '0;
            neg_in_r  <= '0;
            neg_out_r <= 1'b0;
            exp_r     <= '0;
            m         <= '0;
            cnt       <= '0;
            tt_r      <= '0;
            err_r     <= 1'b0;
            match_r   <= 1'b0;
        end else if (accept) begin
            perm_r    <= perm;
            neg_in_r  <= neg_in;
            neg_out_r <= neg_out;
            exp_r     <= exp_tt;
            m         <= '0;
            cnt       <= '0;
            err_r     <= ~perm_ok;
            match_r   <= 1'b0;
            // A rejected run leaves the previous table visible.
            if (perm_ok) tt_r <= '0;
        end else if (state == S_RUN) begin
            if (sample) begin
                tt_r <= tt_next;
                cnt  <= '0;
                if (m == 4'd15) match_r <= (tt_next == exp_r);
                else            m       <= m + 4'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        fn_x = 4'b0000;
        if (state == S_RUN) begin
            for (int i = 0; i < 4; i++) begin
                fn_x[i] = m[perm_r[2*i +: 2]] ^ neg_in_r[i];
            end
        end
    end

    assign busy  = (state == S_RUN);
    assign done  = (state == S_DONE);
    assign err   = err_r;
    assign tt    = tt_r;
    assign match = match_r;

endmodule
